// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared constants, select-width helper and channel state type for clkdiv_multi
package clkdiv_pkg;

    localparam int MIN_DIV   = 2;
    localparam int DIV_W_MAX = 32;

    function automatic int sel_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // Divisor fields are sized for the widest supported DIV_W; upper bits stay zero.
    typedef struct packed {
        logic [DIV_W_MAX-1:0] cnt;
        logic [DIV_W_MAX-1:0] div_a;
        logic [DIV_W_MAX-1:0] div_p;
        logic                 pend;
        logic                 err;
    } chan_state_t;

endpackage

// File: rtl/clkdiv_chan.sv
// rtl/clkdiv_chan.sv - one divider channel: counter, active/pending divisor, registered decode.
// CLKDIV_ODD50_EN adds a negedge flop that stretches odd-divisor clocks to exact 50% duty.
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int DIV_W       = 26,
    parameter int DEFAULT_DIV = 50000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [DIV_W-1:0] val,
    input  logic             en,
    input  logic             sync,
    output logic             clk_out,
    output logic             tick,
    output logic             pend,
    output logic             err
);

    localparam logic [DIV_W_MAX-1:0] DEF = DIV_W_MAX'(DEFAULT_DIV);

    chan_state_t          st;
    chan_state_t          nx;
    logic [DIV_W_MAX-1:0] val_x;
    logic [DIV_W_MAX-1:0] div_wrap;
    logic                 wr_ok;
    logic                 wr_bad;
    logic                 wrap;
    logic                 clk_r;

    always_comb begin
        val_x    = DIV_W_MAX'(val);
        wr_ok    = wr && (val_x >= DIV_W_MAX'(MIN_DIV));
        wr_bad   = wr && !wr_ok;
        wrap     = sync || (st.cnt == st.div_a - 1'b1);
        // A write coinciding with the wrap bypasses the pending stage.
        div_wrap = wr_ok ? val_x : (st.pend ? st.div_p : st.div_a);
        nx       = st;
        if (wr_ok) begin
            nx.div_p = val_x;
            nx.err   = 1'b0;
        end else if (wr_bad) begin
            nx.err = 1'b1;
        end
        if (!en) begin
            nx.div_a = div_wrap;
            nx.cnt   = div_wrap - 1'b1;
            nx.pend  = 1'b0;
        end else if (wrap) begin
            nx.div_a = div_wrap;
            nx.cnt   = '0;
            nx.pend  = 1'b0;
        end else begin
            nx.cnt = st.cnt + 1'b1;
            if (wr_ok) begin
                nx.pend = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st    <= '{cnt: DEF - 1'b1, div_a: DEF, div_p: DEF, pend: 1'b0, err: 1'b0};
            tick  <= 1'b0;
            clk_r <= 1'b0;
        end else begin
            st    <= nx;
            tick  <= en && (nx.cnt == '0);
            clk_r <= en && (nx.cnt < (nx.div_a >> 1));
        end
    end

    assign pend = st.pend;
    assign err  = st.err;

`ifdef CLKDIV_ODD50_EN
    logic odd_r;
    logic neg_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            odd_r <= 1'b0;
        end else begin
            odd_r <= en && nx.div_a[0];
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_r <= 1'b0;
        end else begin
            neg_r <= clk_r;
        end
    end

    assign clk_out = clk_r | (neg_r & odd_r);
`else
    assign clk_out = clk_r;
`endif

endmodule

// File: rtl/clkdiv_multi.sv
// rtl/clkdiv_multi.sv - NCH-channel programmable clock divider with glitch-free updates and phase sync.
// Optional CLKDIV_ODD50_EN gives exact 50% duty on odd divisors.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int CLKFREQ     = 50000000,
    parameter int NCH         = 4,
    parameter int DIV_W       = 26,
    parameter int DEFAULT_DIV = CLKFREQ
) (
    input  logic                      iClk50M,
    input  logic                      iRst_n,
    input  logic                      iDivWr,
    input  logic [sel_width(NCH)-1:0] iDivSel,
    input  logic [DIV_W-1:0]          iDivVal,
    input  logic [NCH-1:0]            iEn,
    input  logic                      iSync,
    output logic [NCH-1:0]            oClk,
    output logic [NCH-1:0]            oTick,
    output logic [NCH-1:0]            oPend,
    output logic [NCH-1:0]            oError
);

    // Selects at or beyond NCH match no channel, so such writes vanish silently.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        clkdiv_chan #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk     (iClk50M),
            .rst_n   (iRst_n),
            .wr      (iDivWr && (32'(iDivSel) == i)),
            .val     (iDivVal),
            .en      (iEn[i]),
            .sync    (iSync),
            .clk_out (oClk[i]),
            .tick    (oTick[i]),
            .pend    (oPend[i]),
            .err     (oError[i])
        );
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
// tb/tb_clkdiv_multi.sv - directed self-checking bench for clkdiv_multi (NCH=2, DIV_W=8, DEFAULT_DIV=4)
module tb_clkdiv_multi;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       div_wr;
    logic [0:0] div_sel;
    logic [7:0] div_val;
    logic [1:0] en;
    logic       sync;
    logic [1:0] oclk, otick, opend, oerr;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int hi;

    clkdiv_multi #(
        .CLKFREQ     (50000000),
        .NCH         (2),
        .DIV_W       (8),
        .DEFAULT_DIV (4)
    ) dut (
        .iClk50M (clk),
        .iRst_n  (rst_n),
        .iDivWr  (div_wr),
        .iDivSel (div_sel),
        .iDivVal (div_val),
        .iEn     (en),
        .iSync   (sync),
        .oClk    (oclk),
        .oTick   (otick),
        .oPend   (opend),
        .oError  (oerr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s @c%0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wr(input logic sel, input logic [7:0] val);
        div_wr  = 1'b1;
        div_sel = sel;
        div_val = val;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; div_wr = 1'b0; div_sel = '0; div_val = '0; en = 2'b11; sync = 1'b0;
        repeat (3) step();
        chk("reset_outputs", {oclk, otick, opend, oerr}, 8'h00);
        rst_n = 1'b1;
        cyc = 0;

        step();
        chk("c1_tick", otick, 2'b11);
        chk("c1_clk", oclk, 2'b11);
        step();
        chk("c2_tick", otick, 2'b00);
        chk("c2_clk", oclk, 2'b11);
        wr(1'b0, 8'd6);
        step();
        div_wr = 1'b0;
        chk("c3_pend", opend, 2'b01);
        chk("c3_clk", oclk, 2'b00);
        step();
        chk("c4_pend", opend, 2'b01);
        step();
        chk("c5_tick", otick, 2'b11);
        chk("c5_pend", opend, 2'b00);
        chk("c5_clk", oclk, 2'b11);
        while (cyc < 17) begin
            step();
            chk("n6_tick", otick, {((cyc - 1) % 4 == 0), ((cyc - 5) % 6 == 0)});
        end

        wr(1'b1, 8'd1);
        step();
        div_wr = 1'b0;
        chk("rej_err", oerr, 2'b10);
        chk("rej_pend", opend, 2'b00);
        while (cyc < 21) begin
            step();
            chk("rej_tick1", otick[1], (cyc == 21));
        end
        chk("rej_err_hold", oerr, 2'b10);

        wr(1'b1, 8'd5);
        step();
        div_wr = 1'b0;
        chk("acc_err", oerr, 2'b00);
        chk("acc_pend", opend, 2'b10);
        while (cyc < 25) step();
        chk("c25_tick", otick, 2'b10);
        chk("c25_pend", opend, 2'b00);
        hi = 0;
        repeat (5) begin
            hi += int'(oclk[1]);
            @(negedge clk);
            #1;
            hi += int'(oclk[1]);
            step();
        end
`ifdef CLKDIV_ODD50_EN
        chk("odd_duty_halves", hi, 5);
`else
        chk("odd_duty_halves", hi, 4);
`endif
        chk("c30_tick1", otick[1], 1'b1);

        while (cyc < 34) step();
        wr(1'b0, 8'd8);
        step();
        div_wr = 1'b0;
        chk("byp_tick0", otick[0], 1'b1);
        chk("byp_pend0", opend[0], 1'b0);
        while (cyc < 43) begin
            step();
            chk("byp_n8_tick0", otick[0], (cyc == 43));
            chk("byp_n8_pend0", opend[0], 1'b0);
        end

        step();
        wr(1'b0, 8'd6);
        step();
        wr(1'b1, 8'd4);
        chk("c45_pend", opend, 2'b01);
        step();
        div_wr = 1'b0;
        chk("c46_pend", opend, 2'b11);
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("sync_tick", otick, 2'b11);
        chk("sync_pend", opend, 2'b00);
        while (cyc < 59) begin
            step();
            chk("sync_period", otick, {((cyc - 47) % 4 == 0), ((cyc - 47) % 6 == 0)});
        end

        en = 2'b10;
        step();
        chk("dis_clk0", oclk[0], 1'b0);
        chk("dis_tick0", otick[0], 1'b0);
        wr(1'b0, 8'd3);
        step();
        div_wr = 1'b0;
        chk("dis_pend0", opend[0], 1'b0);
        step();
        chk("dis_clk0_hold", oclk[0], 1'b0);
        en = 2'b11;
        step();
        chk("reen_tick0", otick[0], 1'b1);
        chk("reen_clk0", oclk[0], 1'b1);
        step();
        chk("reen_c64_tick0", otick[0], 1'b0);
        chk("reen_c64_clk0", oclk[0], 1'b0);
        step();
        step();
        chk("reen_period3", otick[0], 1'b1);

        step();
        chk("pre_reset_tick", otick, 2'b10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {oclk, otick, opend, oerr}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clkdiv_multi.md
# clkdiv_multi

Multi-channel, runtime-programmable clock divider. It derives NCH independent divided clocks and period-start ticks from the 50 MHz board clock, with glitch-free divisor updates and a global phase-sync. It sits beside the G-sensor SPI/sample logic and replaces fixed-ratio, single-output dividers. Each channel's divisor is written by a host register interface.

## Interface
Parameters:
- CLKFREQ, 50000000: input clock frequency in Hz (documentation and default computation only).
- NCH, 4: number of output channels, 1..16.
- DIV_W, 26: divisor/counter width in bits.
- DEFAULT_DIV, 50000000: divisor loaded into every channel at reset, ≥2, <2^DIV_W.

Ports:
- iClk50M  in  1  system clock.
- iRst_n  in  1  reset, asynchronous, active-low.
- iDivWr  in  1  one-cycle divisor write strobe.
- iDivSel  in  max(1,$clog2(NCH))  target channel of the write.
- iDivVal  in  DIV_W  new divisor N for the target channel.
- iEn  in  NCH  per-channel run enable.
- iSync  in  1  restarts all enabled channels in phase.
- oClk  out  NCH  divided clocks, period N cycles.
- oTick  out  NCH  one-cycle pulse in the first cycle of each period.
- oPend  out  NCH  a divisor update is queued and not yet applied.
- oError  out  NCH  sticky flag: last write to this channel was rejected.

## Operation
- Per channel: active divisor `div_a`, pending divisor `div_p`, pending flag, counter `cnt` in [0, div_a-1].
- Period starts when cnt==0. oTick=1 only in that cycle. oClk=1 while cnt < (div_a>>1), else 0. With odd N and no macro, oClk is high for floor(N/2) cycles.
- Wrap: at cnt==div_a-1, the next cnt is 0. If a divisor is pending, div_a←div_p and the flag clears on that same edge. The new period uses the new N. There is never a truncated or stretched period.
- Write acceptance: iDivWr with iDivSel<NCH and iDivVal≥2 sets div_p and the pending flag, and clears oError for that channel. A later write before the wrap overwrites div_p, last write wins.
- Write rejection: iDivVal<2 leaves state unchanged and sets oError. Writes with iDivSel≥NCH are ignored with no flag change.
- A write in the same cycle as a wrap is applied at that wrap (bypass). oPend does not rise.
- Disabled channel (iEn=0): cnt held at div_a-1, and oClk, oTick and oPend... are forced as follows: oClk=0, oTick=0. An accepted write loads div_a directly, so oPend stays 0. On re-enable, the next edge starts a period with cnt=0 and oTick=1.
- iSync=1: every enabled channel is forced to the wrap path on that edge. Any pending divisor is applied, then cnt=0 and oTick=1 in the following cycle. iSync overrides the normal count. A write in the same cycle is applied through the bypass.

## Timing
- Reset values: cnt=DEFAULT_DIV-1, div_a=div_p=DEFAULT_DIV. oClk, oTick, oPend and oError are all 0.
- The first rising edge after reset release with iEn=1 gives cnt=0, oTick=1, oClk=1.
- All outputs are registered and decoded from the next-state count, so they align with cnt. There is no combinational path from inputs to outputs.
- Write to effect: oPend rises 1 cycle after iDivWr and falls in the cycle oTick marks the new period.
- Reset asserted mid-period clears everything asynchronously. Any queued divisor is lost.

## Configuration
- CLKDIV_ODD50_EN defined: each channel adds a negedge flop that samples the posedge oClk term. For odd div_a, oClk = posedge term OR negedge term, giving an exact 50% duty (N/2 cycles high). Even N and oTick are unchanged.
- Not defined: single-edge logic only, and odd N gives floor(N/2) cycles high.

## Structure
- Package clkdiv_pkg: MIN_DIV=2, the channel-select width function, and a typedef for the per-channel state (cnt, div_a, div_p, pend, err).
- Sub-module clkdiv_chan holds one channel's counter, divisor registers, decode and optional negedge path. The top module instantiates it NCH times in a generate loop and decodes iDivSel/iDivWr into per-channel strobes.

## Test plan
- Bench params NCH=2, DIV_W=8, DEFAULT_DIV=4. Release reset with iEn=3 -> oTick on cycles 1, 5, 9. oClk pattern is 1100 repeating on both channels.
- Write ch0 N=6 at cycle 2 -> oPend[0]=1 from cycle 3. Next oTick[0] at cycle 5 with N=6, oPend clears, and subsequent oTick[0] arrive at cycles 11, 17. Channel 1 is unaffected.
- Write ch1 N=1 -> oError[1]=1 and period stays 4. Then write N=5 -> oError[1]=0. Without the macro oClk[1] is high 2 of 5 cycles. With CLKDIV_ODD50_EN it is high 2.5 cycles.
- Write ch0 N=8 in the exact wrap cycle -> the following period is 8 and oPend never rises.
- Ch1 running N=4 and ch0 N=6 out of phase, pulse iSync -> both oTick fire in the next cycle, then stay periodic from that point.
- iEn[0]=0 mid-period -> oClk[0]=0 next cycle. Write N=3 while disabled -> oPend stays 0. Re-enable -> oTick next edge, period 3. Assert reset mid-period -> all outputs 0 immediately.
